mc_control_fsm: RTL and testbench

- Main control sequencer for the multi-cycle MIPS datapath.
- Drives write enables of the holding registers (IR, MDR, A/B, ALUOut), the PC, the register file and the datapath muxes.
- Walks each instruction through fetch, decode, execute, memory and writeback cycles.
- Stalls on a single-port memory through a req/ready handshake.

---
 rtl/mc_pkg.sv | 62 ++++++
 rtl/mc_ctrl_decode.sv | 76 +++++++
 rtl/mc_control_fsm.sv | 115 +++++++++++
 tb/tb_mc_control_fsm.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS control sequencer: states, opcodes,
// datapath mux selects and the packed control word.
package mc_pkg;

    localparam int unsigned ST_W = 4;
    localparam int unsigned OP_W = 6;

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_MEMADR = 4'd3;
    localparam logic [3:0] S_MEMRD  = 4'd4;
    localparam logic [3:0] S_MEMWB  = 4'd5;
    localparam logic [3:0] S_MEMWR  = 4'd6;
    localparam logic [3:0] S_EXEC   = 4'd7;
    localparam logic [3:0] S_ALUWB  = 4'd8;
    localparam logic [3:0] S_BRANCH = 4'd9;
    localparam logic [3:0] S_ADDIEX = 4'd10;
    localparam logic [3:0] S_ADDIWB = 4'd11;
    localparam logic [3:0] S_JUMP   = 4'd12;
    localparam logic [3:0] S_TRAP   = 4'd13;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;

    localparam logic [1:0] ASB_B       = 2'd0;
    localparam logic [1:0] ASB_FOUR    = 2'd1;
    localparam logic [1:0] ASB_IMM     = 2'd2;
    localparam logic [1:0] ASB_IMM_SL2 = 2'd3;

    localparam logic [1:0] PCS_ALU    = 2'd0;
    localparam logic [1:0] PCS_ALUOUT = 2'd1;
    localparam logic [1:0] PCS_JUMP   = 2'd2;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_write;
        logic       mdr_write;
        logic       ab_write;
        logic       aluout_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
    } ctrl_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// State-to-control-word decoder. Moore from state, except the FETCH/MEMRD
// holding-register and PC strobes, which are qualified by mem_ready.
module mc_ctrl_decode
    import mc_pkg::*;
(
    input  logic [ST_W-1:0] state,
    input  logic            mem_ready,
    output ctrl_t           ctrl_c
);

    always_comb begin
        ctrl_c = '0;
        case (state)
            S_FETCH: begin
                ctrl_c.mem_req   = 1'b1;
                ctrl_c.alu_src_b = ASB_FOUR;
                ctrl_c.alu_op    = ALU_ADD;
                ctrl_c.pc_src    = PCS_ALU;
                ctrl_c.ir_write  = mem_ready;
                ctrl_c.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl_c.ab_write     = 1'b1;
                ctrl_c.aluout_write = 1'b1;
                ctrl_c.alu_src_b    = ASB_IMM_SL2;
                ctrl_c.alu_op       = ALU_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                ctrl_c.alu_src_a    = 1'b1;
                ctrl_c.alu_src_b    = ASB_IMM;
                ctrl_c.alu_op       = ALU_ADD;
                ctrl_c.aluout_write = 1'b1;
            end
            S_MEMRD: begin
                ctrl_c.mem_req   = 1'b1;
                ctrl_c.iord      = 1'b1;
                ctrl_c.mdr_write = mem_ready;
            end
            S_MEMWB: begin
                ctrl_c.reg_write  = 1'b1;
                ctrl_c.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl_c.mem_req = 1'b1;
                ctrl_c.mem_we  = 1'b1;
                ctrl_c.iord    = 1'b1;
            end
            S_EXEC: begin
                ctrl_c.alu_src_a    = 1'b1;
                ctrl_c.alu_src_b    = ASB_B;
                ctrl_c.alu_op       = ALU_FUNCT;
                ctrl_c.aluout_write = 1'b1;
            end
            S_ALUWB: begin
                ctrl_c.reg_write = 1'b1;
                ctrl_c.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl_c.alu_src_a     = 1'b1;
                ctrl_c.alu_src_b     = ASB_B;
                ctrl_c.alu_op        = ALU_SUB;
                ctrl_c.pc_write_cond = 1'b1;
                ctrl_c.pc_src        = PCS_ALUOUT;
            end
            S_ADDIWB: begin
                ctrl_c.reg_write = 1'b1;
            end
            S_JUMP: begin
                ctrl_c.pc_write = 1'b1;
                ctrl_c.pc_src   = PCS_JUMP;
            end
            default: ctrl_c = '0;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS control sequencer: state register and next-state logic.
// Optional ILLEGAL_OP_TRAP_EN parks unknown opcodes in TRAP and adds illegal_op.
module mc_control_fsm
    import mc_pkg::*;
#(
    parameter int unsigned OPW = 6,
    parameter int unsigned STW = 4
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [OPW-1:0] opcode,
    input  logic           mem_ready,
    output logic           mem_req,
    output logic           mem_we,
    output logic           iord,
    output logic           ir_write,
    output logic           mdr_write,
    output logic           ab_write,
    output logic           aluout_write,
    output logic           pc_write,
    output logic           pc_write_cond,
    output logic           reg_write,
    output logic           reg_dst,
    output logic           mem_to_reg,
    output logic           alu_src_a,
    output logic [1:0]     alu_src_b,
    output logic [1:0]     alu_op,
    output logic [1:0]     pc_src,
`ifdef ILLEGAL_OP_TRAP_EN
    output logic           illegal_op,
`endif
    output logic [STW-1:0] state
);

    logic [ST_W-1:0] state_q;
    logic [ST_W-1:0] state_d;
    ctrl_t           ctrl_c;

    logic is_rtype, is_lw, is_sw, is_beq, is_addi, is_j;

    assign is_rtype = (opcode == OPW'(OP_RTYPE));
    assign is_lw    = (opcode == OPW'(OP_LW));
    assign is_sw    = (opcode == OPW'(OP_SW));
    assign is_beq   = (opcode == OPW'(OP_BEQ));
    assign is_addi  = (opcode == OPW'(OP_ADDI));
    assign is_j     = (opcode == OPW'(OP_J));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                if (is_rtype)            state_d = S_EXEC;
                else if (is_lw || is_sw) state_d = S_MEMADR;
                else if (is_beq)         state_d = S_BRANCH;
                else if (is_addi)        state_d = S_ADDIEX;
                else if (is_j)           state_d = S_JUMP;
`ifdef ILLEGAL_OP_TRAP_EN
                else                     state_d = S_TRAP;
`else
                else                     state_d = S_FETCH;
`endif
            end
            S_MEMADR: state_d = is_lw ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  if (mem_ready) state_d = S_FETCH;
            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
`ifdef ILLEGAL_OP_TRAP_EN
            S_TRAP:   state_d = S_TRAP;
`endif
            default:  state_d = S_FETCH;
        endcase
    end

    mc_ctrl_decode u_decode (
        .state     (state_q),
        .mem_ready (mem_ready),
        .ctrl_c    (ctrl_c)
    );

    assign mem_req       = ctrl_c.mem_req;
    assign mem_we        = ctrl_c.mem_we;
    assign iord          = ctrl_c.iord;
    assign ir_write      = ctrl_c.ir_write;
    assign mdr_write     = ctrl_c.mdr_write;
    assign ab_write      = ctrl_c.ab_write;
    assign aluout_write  = ctrl_c.aluout_write;
    assign pc_write      = ctrl_c.pc_write;
    assign pc_write_cond = ctrl_c.pc_write_cond;
    assign reg_write     = ctrl_c.reg_write;
    assign reg_dst       = ctrl_c.reg_dst;
    assign mem_to_reg    = ctrl_c.mem_to_reg;
    assign alu_src_a     = ctrl_c.alu_src_a;
    assign alu_src_b     = ctrl_c.alu_src_b;
    assign alu_op        = ctrl_c.alu_op;
    assign pc_src        = ctrl_c.pc_src;
    assign state         = STW'(state_q);

`ifdef ILLEGAL_OP_TRAP_EN
    assign illegal_op = (state_q == S_TRAP);
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed, table-driven bench for mc_control_fsm (both ILLEGAL_OP_TRAP_EN builds).
module tb_mc_control_fsm;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       mem_req, mem_we, iord, ir_write, mdr_write, ab_write, aluout_write;
    logic       pc_write, pc_write_cond, reg_write, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic [3:0] state;
`ifdef ILLEGAL_OP_TRAP_EN
    logic       illegal_op;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mc_control_fsm dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .iord          (iord),
        .ir_write      (ir_write),
        .mdr_write     (mdr_write),
        .ab_write      (ab_write),
        .aluout_write  (aluout_write),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .reg_write     (reg_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_src        (pc_src),
`ifdef ILLEGAL_OP_TRAP_EN
        .illegal_op    (illegal_op),
`endif
        .state         (state)
    );

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_write;
        logic       mdr_write;
        logic       ab_write;
        logic       aluout_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
    } outs_t;

    typedef struct {
        logic [5:0] op;
        logic       rdy;
        logic [3:0] st;
    } vec_t;

    vec_t vecs[$];

    // Reference control word per state, written from the state table.
    function automatic outs_t exp_outs(input logic [3:0] st, input logic rdy);
        outs_t o;
        o = '0;
        case (st)
            4'd1:  begin o.mem_req = 1; o.alu_src_b = 2'd1; o.ir_write = rdy; o.pc_write = rdy; end
            4'd2:  begin o.ab_write = 1; o.aluout_write = 1; o.alu_src_b = 2'd3; end
            4'd3:  begin o.alu_src_a = 1; o.alu_src_b = 2'd2; o.aluout_write = 1; end
            4'd4:  begin o.mem_req = 1; o.iord = 1; o.mdr_write = rdy; end
            4'd5:  begin o.reg_write = 1; o.mem_to_reg = 1; end
            4'd6:  begin o.mem_req = 1; o.mem_we = 1; o.iord = 1; end
            4'd7:  begin o.alu_src_a = 1; o.alu_op = 2'd2; o.aluout_write = 1; end
            4'd8:  begin o.reg_write = 1; o.reg_dst = 1; end
            4'd9:  begin o.alu_src_a = 1; o.alu_op = 2'd1; o.pc_write_cond = 1; o.pc_src = 2'd1; end
            4'd10: begin o.alu_src_a = 1; o.alu_src_b = 2'd2; o.aluout_write = 1; end
            4'd11: begin o.reg_write = 1; end
            4'd12: begin o.pc_write = 1; o.pc_src = 2'd2; end
            default: o = '0;
        endcase
        return o;
    endfunction

    function automatic outs_t act_outs();
        outs_t o;
        o.mem_req = mem_req;         o.mem_we = mem_we;             o.iord = iord;
        o.ir_write = ir_write;       o.mdr_write = mdr_write;       o.ab_write = ab_write;
        o.aluout_write = aluout_write; o.pc_write = pc_write;       o.pc_write_cond = pc_write_cond;
        o.reg_write = reg_write;     o.reg_dst = reg_dst;           o.mem_to_reg = mem_to_reg;
        o.alu_src_a = alu_src_a;     o.alu_src_b = alu_src_b;       o.alu_op = alu_op;
        o.pc_src = pc_src;
        return o;
    endfunction

    task automatic check_now(input string name, input logic [3:0] exp_st, input logic rdy);
        outs_t e, a;
        e = exp_outs(exp_st, rdy);
        a = act_outs();
        checks++;
        if (state !== exp_st) begin
            failures++;
            $display("FAIL %s state: got %0d expected %0d", name, state, exp_st);
        end
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s outputs (state %0d): got %05h expected %05h", name, exp_st, a, e);
        end
`ifdef ILLEGAL_OP_TRAP_EN
        checks++;
        if (illegal_op !== (exp_st == 4'd13)) begin
            failures++;
            $display("FAIL %s illegal_op: got %b expected %b", name, illegal_op, exp_st == 4'd13);
        end
`endif
    endtask

    task automatic run_row(input string name, input vec_t v);
        @(negedge clk);
        opcode    = v.op;
        mem_ready = v.rdy;
        #1;
        check_now(name, v.st, v.rdy);
    endtask

    task automatic add(input logic [5:0] op, input logic rdy, input logic [3:0] st);
        vec_t v;
        v.op = op; v.rdy = rdy; v.st = st;
        vecs.push_back(v);
    endtask

    initial begin
        // R-type, ready tied high elsewhere but ignored outside memory states
        add(6'h00, 1, 1); add(6'h00, 1, 2); add(6'h00, 0, 7); add(6'h00, 0, 8);
        // LW with two wait states in MEMRD
        add(6'h23, 1, 1); add(6'h23, 1, 2); add(6'h23, 1, 3);
        add(6'h23, 0, 4); add(6'h23, 0, 4); add(6'h23, 1, 4); add(6'h23, 1, 5);
        // SW, BEQ, J back-to-back
        add(6'h2B, 1, 1); add(6'h2B, 1, 2); add(6'h2B, 1, 3); add(6'h2B, 1, 6);
        add(6'h04, 1, 1); add(6'h04, 1, 2); add(6'h04, 1, 9);
        add(6'h02, 1, 1); add(6'h02, 1, 2); add(6'h02, 1, 12);
        // ADDI after a five-cycle FETCH stall
        for (int i = 0; i < 5; i++) add(6'h08, 0, 1);
        add(6'h08, 1, 1); add(6'h08, 1, 2); add(6'h08, 1, 10); add(6'h08, 1, 11);
        // SW with one wait state in MEMWR
        add(6'h2B, 1, 1); add(6'h2B, 1, 2); add(6'h2B, 1, 3); add(6'h2B, 0, 6); add(6'h2B, 1, 6);
        // Unknown opcode
        add(6'h3F, 1, 1); add(6'h3F, 1, 2);
`ifdef ILLEGAL_OP_TRAP_EN
        add(6'h3F, 1, 13); add(6'h00, 1, 13); add(6'h00, 0, 13);
`else
        add(6'h3F, 1, 1);
`endif

        reset_n   = 1'b0;
        opcode    = 6'h00;
        mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_now("reset_idle", 4'd0, 1'b1);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check_now("idle_after_release", 4'd0, 1'b1);

        foreach (vecs[i]) run_row($sformatf("vec%0d", i), vecs[i]);

        // Reset asserted mid-MEMRD: state and mem_req drop without a clock edge
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        begin
            vec_t v;
            v.op = 6'h23; v.rdy = 1; v.st = 1; run_row("rst_lw_fetch", v);
            v.st = 2; run_row("rst_lw_decode", v);
            v.st = 3; run_row("rst_lw_memadr", v);
            v.rdy = 0; v.st = 4; run_row("rst_lw_memrd", v);
        end
        #2;
        reset_n = 1'b0;
        #1;
        check_now("async_reset_memrd", 4'd0, 1'b0);
        checks++;
        if (mem_req !== 1'b0) begin
            failures++;
            $display("FAIL async_reset_mem_req: got %b expected 0", mem_req);
        end
        @(negedge clk);
        reset_n   = 1'b1;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        check_now("fetch_after_release", 4'd1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
